umem_uart_ctrl: RTL

UMEM_UART_CTRL -- requirements
Module: umem_uart_ctrl

---
 rtl/umem_uart_ctrl_if.sv | 47 ++++
 rtl/umem_uart_ctrl.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/umem_uart_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : umem_uart_ctrl_if
// Description : Bundles the UART byte streams, the UART-side memory port and
//               the status flags of umem_uart_ctrl.
//               slave  : controller side (drives tx, memory strobes, status)
//               master : environment side (drives rx, tx_ready, read data)
// Signals     : rx_valid/rx_data     received-byte strobe and byte
//               tx_valid/tx_data     transmit offer, tx_ready accepts it
//               umem_ctrl            UART owns the memory when high
//               umem_rd_en/wr_en     one-cycle memory strobes
//               umem_addr            byte address
//               umem_wr_data         write byte
//               umem_rd_data         combinational read data for umem_addr
//               busy, rx_overrun     status flags
// Revision    : 1.0 - initial release
// ============================================================================
interface umem_uart_ctrl_if #(
  parameter int MEM_BYTE_ADDR_WIDTH = 6
);
  logic                           rx_valid;
  logic [7:0]                     rx_data;
  logic                           tx_valid;
  logic [7:0]                     tx_data;
  logic                           tx_ready;
  logic                           umem_ctrl;
  logic                           umem_rd_en;
  logic                           umem_wr_en;
  logic [MEM_BYTE_ADDR_WIDTH-1:0] umem_addr;
  logic [7:0]                     umem_wr_data;
  logic [7:0]                     umem_rd_data;
  logic                           busy;
  logic                           rx_overrun;

  modport slave (
    input  rx_valid, rx_data, tx_ready, umem_rd_data,
    output tx_valid, tx_data, umem_ctrl, umem_rd_en, umem_wr_en,
           umem_addr, umem_wr_data, busy, rx_overrun
  );

  modport master (
    output rx_valid, rx_data, tx_ready, umem_rd_data,
    input  tx_valid, tx_data, umem_ctrl, umem_rd_en, umem_wr_en,
           umem_addr, umem_wr_data, busy, rx_overrun
  );
endinterface
`default_nettype wire

// File: rtl/umem_uart_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : umem_uart_ctrl
// Description : Byte-command controller giving a UART access to a small byte
//               memory. Commands: RELEASE / ACQUIRE memory ownership, and
//               WRITE / READ bursts of 1..256 bytes starting at an address
//               carried in the command byte. Read data is streamed back over
//               the transmit handshake.
// Ports       : clk  - single clock, rising edge
//               rst  - synchronous, active-high reset
//               bus  - umem_uart_ctrl_if.slave (rx, tx, memory port, status)
// Parameters  : MEM_BYTE_ADDR_WIDTH - memory byte-address width, 1..6
// Config      : UMEM_UART_ACK_EN - when defined, RELEASE, ACQUIRE and every
//               completed WRITE burst are acknowledged with a transmitted
//               8'hA5. When undefined, only read data is transmitted.
// Revision    : 1.0 - initial release
// ============================================================================
module umem_uart_ctrl #(
  parameter int MEM_BYTE_ADDR_WIDTH = 6
) (
  input  wire logic        clk,
  input  wire logic        rst,
  umem_uart_ctrl_if.slave  bus
);

  localparam int               AW       = MEM_BYTE_ADDR_WIDTH;
  localparam logic [AW-1:0]    ADDR_ONE = AW'(1);
  localparam logic [1:0]       OP_RELEASE = 2'b00;
  localparam logic [1:0]       OP_ACQUIRE = 2'b01;
  localparam logic [7:0]       ACK_BYTE   = 8'hA5;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LEN   = 3'd1,
    S_WDATA = 3'd2,
    S_WR    = 3'd3,
    S_RD    = 3'd4,
    S_SEND  = 3'd5
`ifdef UMEM_UART_ACK_EN
    ,
    S_ACK   = 3'd6
`endif
  } state_t;

  // Where RELEASE, ACQUIRE and the end of a WRITE burst lead.
`ifdef UMEM_UART_ACK_EN
  localparam state_t S_DONE = S_ACK;
`else
  localparam state_t S_DONE = S_IDLE;
`endif

  state_t        state_q,   state_d;
  logic          ctrl_q,    ctrl_d;
  logic          is_read_q, is_read_d;
  logic [AW-1:0] addr_q,    addr_d;
  logic [8:0]    cnt_q,     cnt_d;     // 9 bits so a length byte of 0 means 256
  logic [7:0]    wr_data_q, wr_data_d;
  logic [7:0]    tx_data_q, tx_data_d;
  logic          overrun_q, overrun_d;

  always_comb begin
    state_d   = state_q;
    ctrl_d    = ctrl_q;
    is_read_d = is_read_q;
    addr_d    = addr_q;
    cnt_d     = cnt_q;
    wr_data_d = wr_data_q;
    tx_data_d = tx_data_q;
    overrun_d = overrun_q;

    case (state_q)
      S_IDLE: begin
        if (bus.rx_valid) begin
          case (bus.rx_data[7:6])
            OP_RELEASE: begin
              ctrl_d  = 1'b0;
              state_d = S_DONE;
            end
            OP_ACQUIRE: begin
              ctrl_d  = 1'b1;
              state_d = S_DONE;
            end
            default: begin
              // Bit 6 separates READ (11) from WRITE (10).
              addr_d    = bus.rx_data[AW-1:0];
              is_read_d = bus.rx_data[6];
              state_d   = S_LEN;
            end
          endcase
        end
      end

      S_LEN: begin
        if (bus.rx_valid) begin
          cnt_d   = {(bus.rx_data == 8'h00), bus.rx_data};
          state_d = is_read_q ? S_RD : S_WDATA;
        end
      end

      S_WDATA: begin
        if (bus.rx_valid) begin
          wr_data_d = bus.rx_data;
          state_d   = S_WR;
        end
      end

      // Write (or discard) cycle. A byte landing here is the next burst byte
      // and is written on the following cycle at the incremented address;
      // after the last byte of the burst there is nowhere to put it.
      S_WR: begin
        addr_d = addr_q + ADDR_ONE;
        cnt_d  = cnt_q - 9'd1;
        if (cnt_q == 9'd1) begin
          state_d = S_DONE;
          if (bus.rx_valid) begin
            overrun_d = 1'b1;
          end
        end else if (bus.rx_valid) begin
          wr_data_d = bus.rx_data;
        end else begin
          state_d = S_WDATA;
        end
      end

      S_RD: begin
        tx_data_d = ctrl_q ? bus.umem_rd_data : 8'h00;
        state_d   = S_SEND;
        if (bus.rx_valid) begin
          overrun_d = 1'b1;
        end
      end

      S_SEND: begin
        if (bus.rx_valid) begin
          overrun_d = 1'b1;
        end
        if (bus.tx_ready) begin
          addr_d  = addr_q + ADDR_ONE;
          cnt_d   = cnt_q - 9'd1;
          state_d = (cnt_q == 9'd1) ? S_IDLE : S_RD;
        end
      end

`ifdef UMEM_UART_ACK_EN
      S_ACK: begin
        if (bus.rx_valid) begin
          overrun_d = 1'b1;
        end
        if (bus.tx_ready) begin
          state_d = S_IDLE;
        end
      end
`endif

      default: begin
        state_d = S_IDLE;
      end
    endcase

`ifdef UMEM_UART_ACK_EN
    // Load the acknowledge byte on entry so it is stable for the whole offer.
    if ((state_d == S_ACK) && (state_q != S_ACK)) begin
      tx_data_d = ACK_BYTE;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      ctrl_q    <= 1'b0;
      is_read_q <= 1'b0;
      addr_q    <= '0;
      cnt_q     <= 9'd0;
      wr_data_q <= 8'h00;
      tx_data_q <= 8'h00;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ctrl_q    <= ctrl_d;
      is_read_q <= is_read_d;
      addr_q    <= addr_d;
      cnt_q     <= cnt_d;
      wr_data_q <= wr_data_d;
      tx_data_q <= tx_data_d;
      overrun_q <= overrun_d;
    end
  end

  // Strobes come from distinct states, so they can never overlap and are
  // never active in IDLE or LEN. Without ownership they are suppressed.
  assign bus.umem_wr_en   = (state_q == S_WR) && ctrl_q;
  assign bus.umem_rd_en   = (state_q == S_RD) && ctrl_q;
  assign bus.umem_ctrl    = ctrl_q;
  assign bus.umem_addr    = addr_q;
  assign bus.umem_wr_data = wr_data_q;
  assign bus.tx_data      = tx_data_q;
  assign bus.busy         = (state_q != S_IDLE);
  assign bus.rx_overrun   = overrun_q;
`ifdef UMEM_UART_ACK_EN
  assign bus.tx_valid     = (state_q == S_SEND) || (state_q == S_ACK);
`else
  assign bus.tx_valid     = (state_q == S_SEND);
`endif

endmodule
`default_nettype wire
